// File: rtl/axi_sram_adapter.sv
// AXI burst slave that turns write/read bursts into single-beat accesses on a
// synchronous single-port SRAM, one burst at a time, with round-robin aw/ar arbitration.
module axi_sram_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                    state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [8:0]                issue_left_reg, issue_left_next;
  logic [8:0]                rx_left_reg, rx_left_next;
  logic                      last_wr_reg, last_wr_next;
  logic                      inflight_reg;
  logic [1:0]                fifo_cnt_reg, fifo_cnt_next;
  logic                      wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0]     fifo_mem [2];

  logic                      grant_wr, grant_rd, push, pop;
  logic [1:0]                occ;
  logic [ADDR_WIDTH-1:0]     aw_word, ar_word;
  logic                      unused_bits;

  assign aw_word     = awaddr >> SHIFT;
  assign ar_word     = araddr >> SHIFT;
  assign unused_bits = ^{wlast, aw_word, ar_word};

  // Data for a read issued last cycle is on mem_rdata now.
  assign push   = inflight_reg;
  assign rvalid = (fifo_cnt_reg != 2'd0);
  assign pop    = rvalid && rready;
  assign rdata  = fifo_mem[rd_ptr_reg];
  assign rlast  = rvalid && (rx_left_reg == 9'd1);
  // Counting the slot freed by this cycle's pop keeps back-to-back reads flowing.
  assign occ    = fifo_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    issue_left_next = issue_left_reg;
    rx_left_next    = rx_left_reg;
    last_wr_next    = last_wr_reg;
    awready         = 1'b0;
    arready         = 1'b0;
    wready          = 1'b0;
    bvalid          = 1'b0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    grant_wr        = awvalid && (!arvalid || !last_wr_reg);
    grant_rd        = arvalid && !grant_wr;
    case (state_reg)
      IDLE: begin
        awready = grant_wr;
        arready = grant_rd;
        if (grant_wr) begin
          state_next      = WRITE;
          addr_next       = aw_word[MEM_ADDR_WIDTH-1:0];
          issue_left_next = {1'b0, awlen} + 9'd1;
          last_wr_next    = 1'b1;
        end else if (grant_rd) begin
          state_next      = READ;
          addr_next       = ar_word[MEM_ADDR_WIDTH-1:0];
          issue_left_next = {1'b0, arlen} + 9'd1;
          rx_left_next    = {1'b0, arlen} + 9'd1;
          last_wr_next    = 1'b0;
        end
      end
      WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we          = 1'b1;
          addr_next       = addr_reg + 1'b1;
          issue_left_next = issue_left_reg - 9'd1;
          if (issue_left_reg == 9'd1) state_next = WRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_next = IDLE;
      end
      READ: begin
        if (issue_left_reg != 9'd0 && occ < 2'd2) begin
          mem_re          = 1'b1;
          addr_next       = addr_reg + 1'b1;
          issue_left_next = issue_left_reg - 9'd1;
        end
        if (pop) begin
          rx_left_next = rx_left_reg - 9'd1;
          if (rx_left_reg == 9'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 2'd1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 2'd1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      issue_left_reg <= '0;
      rx_left_reg    <= '0;
      last_wr_reg    <= 1'b0;
      inflight_reg   <= 1'b0;
      fifo_cnt_reg   <= '0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      issue_left_reg <= issue_left_next;
      rx_left_reg    <= rx_left_next;
      last_wr_reg    <= last_wr_next;
      inflight_reg   <= mem_re;
      fifo_cnt_reg   <= fifo_cnt_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_rdata;
  end
endmodule
